output_buffer_acc: RTL and testbench

Parametrised multi-channel output buffer for the systolic array result path.
- Accepts up to N_CH concurrent result writes per cycle from the array column drains, each either overwriting or accumulating into a DEPTH-entry store.
- Presents results to the external interface through a valid/ready port, as a single-address read or a full sequential drain that clears the buffer.

---
 rtl/output_buffer_acc_pkg.sv | 21 ++
 rtl/output_buffer_acc_if.sv | 45 ++++
 rtl/obuf_write_arbiter.sv | 51 +++++
 rtl/output_buffer_acc.sv | 165 ++++++++++++++++
 tb/tb_output_buffer_acc.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_buffer_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module : output_buffer_acc_pkg
// Desc   : Shared defaults and FSM state encoding for the output_buffer_acc
//          result buffer (top, interface and write arbiter).
// Rev    : 1.0  initial release
// ============================================================================
package output_buffer_acc_pkg;

  localparam int OBUF_DATA_W = 32;  // width of one result word
  localparam int OBUF_DEPTH  = 16;  // number of entries, power of two >= 2
  localparam int OBUF_N_CH   = 4;   // parallel write channels

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_DRAIN  = 2'd2
  } obuf_state_e;

endpackage
`default_nettype wire

// File: rtl/output_buffer_acc_if.sv
`default_nettype none
// ============================================================================
// Module : output_buffer_acc_if
// Desc   : Bundles the column-drain write channels, the read/drain request
//          inputs, the valid/ready result port and the status outputs.
//          master : producer/consumer side (array drains + external reader)
//          slave  : the buffer itself
// Rev    : 1.0  initial release
// ============================================================================
interface output_buffer_acc_if
  import output_buffer_acc_pkg::*;
#(
  parameter int DATA_W = OBUF_DATA_W,
  parameter int DEPTH  = OBUF_DEPTH,
  parameter int N_CH   = OBUF_N_CH,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [N_CH-1:0]        wr_en;        // per-channel write strobe
  logic [N_CH*ADDR_W-1:0] wr_addr;      // channel c at [c*ADDR_W +: ADDR_W]
  logic [N_CH*DATA_W-1:0] wr_data;      // channel c at [c*DATA_W +: DATA_W]
  logic                   wr_acc;       // 1 accumulate, 0 overwrite
  logic                   rd_req;       // single read request
  logic [ADDR_W-1:0]      rd_addr;      // single read address
  logic                   drain_start;  // start full sequential drain
  logic                   out_valid;    // out_data/out_addr valid
  logic                   out_ready;    // consumer accepts current beat
  logic [DATA_W-1:0]      out_data;     // result word
  logic [ADDR_W-1:0]      out_addr;     // entry index of out_data
  logic                   out_last;     // final beat of a drain
  logic                   busy;         // FSM not idle
  logic [DEPTH-1:0]       entry_valid;  // written-since-clear flags
  logic                   wr_conflict;  // address collision seen last cycle

  modport master (
    output wr_en, wr_addr, wr_data, wr_acc, rd_req, rd_addr, drain_start, out_ready,
    input  out_valid, out_data, out_addr, out_last, busy, entry_valid, wr_conflict
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_acc, rd_req, rd_addr, drain_start, out_ready,
    output out_valid, out_data, out_addr, out_last, busy, entry_valid, wr_conflict
  );

endinterface
`default_nettype wire

// File: rtl/obuf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : obuf_write_arbiter
// Desc   : Combinational reduction of N_CH write channels to per-entry
//          write enables and data. Lowest-index channel wins a shared
//          address; any shared address raises conflict.
// Ports  : wr_en/wr_addr/wr_data  packed channel requests
//          ent_we/ent_wdata        per-entry winning write
//          conflict                two or more enabled channels collided
// Rev    : 1.0  initial release
// ============================================================================
module obuf_write_arbiter
  import output_buffer_acc_pkg::*;
#(
  parameter int DATA_W = OBUF_DATA_W,
  parameter int DEPTH  = OBUF_DEPTH,
  parameter int N_CH   = OBUF_N_CH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic [N_CH-1:0]              wr_en,
  input  wire logic [N_CH*ADDR_W-1:0]       wr_addr,
  input  wire logic [N_CH*DATA_W-1:0]       wr_data,
  output logic      [DEPTH-1:0]             ent_we,
  output logic      [DEPTH-1:0][DATA_W-1:0] ent_wdata,
  output logic                              conflict
);

  always_comb begin
    ent_we    = '0;
    ent_wdata = '0;
    conflict  = 1'b0;
    // Walk from the highest channel down so the lowest index is written last
    // and therefore owns the entry.
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (wr_en[c]) begin
        ent_we[wr_addr[c*ADDR_W +: ADDR_W]]    = 1'b1;
        ent_wdata[wr_addr[c*ADDR_W +: ADDR_W]] = wr_data[c*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      for (int j = i + 1; j < N_CH; j++) begin
        if (wr_en[i] && wr_en[j] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])) begin
          conflict = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/output_buffer_acc.sv
`default_nettype none
// ============================================================================
// Module : output_buffer_acc
// Desc   : Multi-channel result buffer for the systolic array. Column drains
//          overwrite or accumulate into a DEPTH-entry store; results leave
//          through a valid/ready port as a single read or a full drain that
//          clears each entry as it is accepted.
// Ports  : clk  rising-edge clock
//          rst  asynchronous active-high reset
//          bus  output_buffer_acc_if.slave (writes, requests, result port,
//               busy / entry_valid / wr_conflict status)
// Rev    : 1.0  initial release
// ============================================================================
module output_buffer_acc
  import output_buffer_acc_pkg::*;
#(
  parameter int DATA_W = OBUF_DATA_W,
  parameter int DEPTH  = OBUF_DEPTH,
  parameter int N_CH   = OBUF_N_CH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input wire logic           clk,
  input wire logic           rst,
  output_buffer_acc_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  obuf_state_e state_q, state_d;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_W-1:0]            out_data_q, out_data_d;
  logic [ADDR_W-1:0]            out_addr_q, out_addr_d;
  logic                         out_last_q, out_last_d;
  logic                         wr_conflict_q, wr_conflict_d;

  logic [DEPTH-1:0]             ent_we;
  logic [DEPTH-1:0][DATA_W-1:0] ent_wdata;
  logic                         hs;
  logic                         drain_clr;
  logic [ADDR_W-1:0]            next_addr;

  obuf_write_arbiter #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .N_CH   (N_CH),
    .ADDR_W (ADDR_W)
  ) u_arb (
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .ent_we    (ent_we),
    .ent_wdata (ent_wdata),
    .conflict  (wr_conflict_d)
  );

  assign hs        = out_valid_q & bus.out_ready;
  assign drain_clr = (state_q == ST_DRAIN) && hs;
  assign next_addr = out_addr_q + 1'b1;

  // Storage: a committing write always beats the drain clear of the same entry.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_we[e]) begin
        mem_d[e] = (bus.wr_acc && vld_q[e]) ? mem_q[e] + ent_wdata[e] : ent_wdata[e];
        vld_d[e] = 1'b1;
      end else if (drain_clr && (out_addr_q == ADDR_W'(e))) begin
        mem_d[e] = '0;
        vld_d[e] = 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; requests are only looked at while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.drain_start)  state_d = ST_DRAIN;
        else if (bus.rd_req)  state_d = ST_SINGLE;
      end
      ST_SINGLE: if (hs) state_d = ST_IDLE;
      ST_DRAIN:  if (hs && out_last_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: the result register reads mem_q, i.e. before this edge's
  // writes, and only moves on a load or a handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.drain_start) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[0];
          out_addr_d  = '0;
          out_last_d  = 1'b0;
        end else if (bus.rd_req) begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[bus.rd_addr];
          out_addr_d  = bus.rd_addr;
          out_last_d  = 1'b0;
        end
      end
      ST_SINGLE: if (hs) out_valid_d = 1'b0;
      ST_DRAIN: begin
        if (hs) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = mem_q[next_addr];
            out_addr_d = next_addr;
            out_last_d = (next_addr == LAST_ADDR);
          end
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q         <= '0;
      vld_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      out_last_q    <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      vld_q         <= vld_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
      out_last_q    <= out_last_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.entry_valid = vld_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_output_buffer_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_output_buffer_acc
// Desc   : Directed and randomized stimulus for output_buffer_acc, checked
//          every cycle against a behavioural model of the buffer contents
//          and of the expected result beat.
// Rev    : 1.0  initial release
// ============================================================================
module tb_output_buffer_acc;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int N_CH   = 4;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  output_buffer_acc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH), .ADDR_W(ADDR_W)) bus ();

  output_buffer_acc #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: buffer contents, flags, and the beat the port should show.
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  int          m_mode;      // 0 idle, 1 single read, 2 drain
  bit          m_ov;
  logic [31:0] m_od;
  int          m_oa;
  bit          m_ol;
  bit          m_conf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_vld[i] = 1'b0;
    end
    m_mode = 0; m_ov = 0; m_od = '0; m_oa = 0; m_ol = 0; m_conf = 0;
  endtask

  // Evaluate what the coming clock edge must do, from the current inputs.
  task automatic model_update();
    logic [31:0] nmem [DEPTH];
    bit          nvld [DEPTH];
    bit          claimed [DEPTH];
    bit          hs;
    bit          conf;
    int          a;
    logic [31:0] d;
    conf = 0;
    for (int i = 0; i < DEPTH; i++) begin
      nmem[i] = m_mem[i]; nvld[i] = m_vld[i]; claimed[i] = 0;
    end
    hs = m_ov && bus.out_ready;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.wr_en[c]) begin
        a = int'(bus.wr_addr[c*ADDR_W +: ADDR_W]);
        d = bus.wr_data[c*DATA_W +: DATA_W];
        if (claimed[a]) conf = 1;
        else begin
          claimed[a] = 1;
          nmem[a] = (bus.wr_acc && m_vld[a]) ? m_mem[a] + d : d;
          nvld[a] = 1;
        end
      end
    end
    if (m_mode == 0) begin
      if (bus.drain_start) begin
        m_mode = 2; m_ov = 1; m_oa = 0; m_od = m_mem[0]; m_ol = 0;
      end else if (bus.rd_req) begin
        m_mode = 1; m_ov = 1; m_oa = int'(bus.rd_addr); m_od = m_mem[m_oa]; m_ol = 0;
      end
    end else if (m_mode == 1) begin
      if (hs) begin m_mode = 0; m_ov = 0; end
    end else if (hs) begin
      if (!claimed[m_oa]) begin nmem[m_oa] = '0; nvld[m_oa] = 0; end
      if (m_oa == DEPTH - 1) begin
        m_mode = 0; m_ov = 0; m_ol = 0;
      end else begin
        m_oa = m_oa + 1; m_od = m_mem[m_oa]; m_ol = (m_oa == DEPTH - 1);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = nmem[i]; m_vld[i] = nvld[i];
    end
    m_conf = conf;
  endtask

  task automatic compare_all(input string tag);
    logic [DEPTH-1:0] ev;
    for (int i = 0; i < DEPTH; i++) ev[i] = m_vld[i];
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_ov));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(m_mode != 0));
    chk({tag, ".wr_conflict"}, 64'(bus.wr_conflict), 64'(m_conf));
    chk({tag, ".entry_valid"}, 64'(bus.entry_valid), 64'(ev));
    if (m_ov) begin
      chk({tag, ".out_data"}, 64'(bus.out_data), 64'(m_od));
      chk({tag, ".out_addr"}, 64'(bus.out_addr), 64'(m_oa));
      chk({tag, ".out_last"}, 64'(bus.out_last), 64'(m_ol));
    end
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_acc = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.drain_start = 1'b0;
  endtask

  task automatic wr1(input int ch, input int a, input logic [31:0] d, input bit acc);
    bus.wr_en = '0;
    bus.wr_en[ch] = 1'b1;
    bus.wr_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.wr_data[ch*DATA_W +: DATA_W] = d;
    bus.wr_acc = acc;
  endtask

  // Single read of address a; checks the first beat against a literal too.
  task automatic read_expect(input string tag, input int a, input logic [31:0] exp);
    idle_inputs();
    bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(a); bus.out_ready = 1'b0;
    step({tag, ".req"});
    bus.rd_req = 1'b0;
    chk({tag, ".lit"}, 64'(bus.out_data), 64'(exp));
    bus.out_ready = 1'b1;
    step({tag, ".hs"});
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Drain of an empty buffer: 16 zero beats, then busy drops.
    bus.drain_start = 1'b1;
    step("drain0");
    bus.drain_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain0.zero", 64'(bus.out_data), 64'h0);
      step("drain0");
    end
    chk("drain0.busy_end", 64'(bus.busy), 64'h0);

    // Overwrite then accumulate into entry 3.
    wr1(0, 3, 32'h10, 1'b0); step("ow3");
    wr1(1, 3, 32'h05, 1'b1); step("acc3");
    read_expect("rd3", 3, 32'h15);
    chk("rd3.valid_kept", 64'(bus.entry_valid[3]), 64'h1);

    // Modulo wrap on accumulate, and accumulate into a never-written entry.
    wr1(2, 9, 32'h2, 1'b0); step("ow9");
    wr1(3, 9, 32'hFFFF_FFFF, 1'b1); step("acc9");
    read_expect("rd9", 9, 32'h1);
    wr1(0, 7, 32'h9, 1'b1); step("acc7");
    read_expect("rd7", 7, 32'h9);

    // Collision: ch0 and ch2 both hit entry 5.
    idle_inputs();
    bus.wr_en = 4'b0101;
    bus.wr_addr[0 +: ADDR_W] = 4'd5; bus.wr_addr[2*ADDR_W +: ADDR_W] = 4'd5;
    bus.wr_data[0 +: DATA_W] = 32'hA; bus.wr_data[2*DATA_W +: DATA_W] = 32'hB;
    step("coll");
    chk("coll.pulse", 64'(bus.wr_conflict), 64'h1);
    idle_inputs();
    step("coll.after");
    chk("coll.gone", 64'(bus.wr_conflict), 64'h0);
    read_expect("rd5", 5, 32'hA);

    // Drain with stalls; write to entry 4 on its handshake edge.
    idle_inputs();
    bus.drain_start = 1'b1;
    step("drain1.start");
    bus.drain_start = 1'b0;
    for (int i = 0; i < 80 && m_mode != 0; i++) begin
      bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      if (m_ov && m_oa == 4 && bus.out_ready) wr1(1, 4, 32'h44, 1'b0);
      else idle_inputs();
      step("drain1");
    end
    chk("drain1.done", 64'(m_mode != 0 || bus.busy), 64'h0);
    bus.out_ready = 1'b1;
    read_expect("rd4", 4, 32'h44);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.wr_en = N_CH'($urandom_range(0, 15));
      for (int c = 0; c < N_CH; c++) begin
        bus.wr_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
        bus.wr_data[c*DATA_W +: DATA_W] = $urandom;
      end
      bus.wr_acc      = 1'($urandom_range(0, 1));
      bus.rd_req      = ($urandom_range(0, 7) == 0);
      bus.rd_addr     = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.drain_start = ($urandom_range(0, 15) == 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Reset in the middle of a drain (at beat 6), then verify an all-zero drain.
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && m_mode != 0; i++) step("flush");
    for (int i = 0; i < 4; i++) begin
      wr1(i, 2 * i + 1, $urandom | 32'h1, 1'b0);
      step("prefill");
    end
    idle_inputs();
    bus.drain_start = 1'b1;
    step("drain2.start");
    bus.drain_start = 1'b0;
    for (int i = 0; i < 20 && m_oa != 6; i++) step("drain2");
    chk("drain2.at6", 64'(bus.out_addr), 64'h6);
    rst = 1'b1;
    #1;
    chk("arst.out_valid", 64'(bus.out_valid), 64'h0);
    chk("arst.busy", 64'(bus.busy), 64'h0);
    chk("arst.entry_valid", 64'(bus.entry_valid), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("arst.after");
    bus.drain_start = 1'b1;
    step("drain3.start");
    bus.drain_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain3.zero", 64'(bus.out_data), 64'h0);
      step("drain3");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
